uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Receive-side UART control and datapath. It is the counterpart of the existing transmitter FSM.
- Deserialises an asynchronous serial line into DATA_WIDTH-bit words (start, data LSB-first, optional parity, stop).
- Runs on an oversampled baud clock and samples each bit at its midpoint.
- Flags each frame as valid, parity-errored or framing-errored.
- Sits between the serial RX pin and the receive buffer/host logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- OVERSAMPLE, 16, baud_rate_rx cycles per bit period. Must be even and ≥ 4.
- PARITY_EN, 1, 1 = one parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- baud_rate_rx, in, 1, receive clock at OVERSAMPLE × bit rate.
- rst_n, in, 1, synchronous active-low reset.
- rx_enable, in, 1, allows a new frame to start. Only sampled in IDLE.
- rx_in, in, 1, asynchronous serial line. Idle level is 1.
- rx_data, out, DATA_WIDTH, last received word. Held until the next frame completes.
- data_valid, out, 1, one-cycle pulse when a good frame completes.
- parity_error, out, 1, one-cycle pulse when the parity bit mismatches.
- framing_error, out, 1, one-cycle pulse when the stop bit is sampled as 0.
- busy, out, 1, high whenever the state is not IDLE.

Behaviour:
- Clock and reset: single clock baud_rate_rx. Reset is synchronous and active-low on rst_n.
- Reset values: rx_data = 0, data_valid = 0, parity_error = 0, framing_error = 0, busy = 0, state = IDLE, all counters = 0, synchroniser flops = 1.
- Reset mid-frame: on the next clock edge, abandon the frame, return to IDLE and emit no pulses.
- Input synchroniser: rx_in passes through 2 flops to give rx_s. All decisions use rx_s, so there are 2 cycles of input latency.
- tick_cnt counts 0 to OVERSAMPLE-1 and clears on every state entry.
- bit_cnt counts 0 to DATA_WIDTH-1.
- IDLE: if rx_enable = 1 and rx_s = 0, go to START.
- START: at tick_cnt = OVERSAMPLE/2-1, sample rx_s (mid start bit).
  - rx_s = 1: false start. Return to IDLE with no pulses.
  - rx_s = 0: go to DATA.
- DATA: at tick_cnt = OVERSAMPLE-1 (mid bit), shift rx_s into the MSB of the shift register (right shift, so LSB-first data lands in order) and increment bit_cnt.
  - After bit DATA_WIDTH-1, go to PARITY if PARITY_EN = 1, else go to STOP.
- PARITY: at tick_cnt = OVERSAMPLE-1, latch par_ok.
  - par_ok = (XOR of data bits ^ rx_s ^ PARITY_ODD) == 0.
  - Then go to STOP.
- STOP: at tick_cnt = OVERSAMPLE-1 (mid stop bit), on the same edge:
  - Load rx_data from the shift register.
  - framing_error = ~rx_s.
  - parity_error = PARITY_EN & ~par_ok.
  - data_valid = rx_s & (par_ok | ~PARITY_EN).
  - Return to IDLE. The second half of the stop bit is spent in IDLE, so the next start edge is caught without slip.
- Error combinations: a parity error and a framing error may pulse together. data_valid is never high in the same cycle as either error flag.
- rx_enable deasserted mid-frame: the frame completes normally. rx_enable only gates leaving IDLE.
- Line held at 0 (break condition): produces framing_error. The FSM then re-enters START immediately while rx_s stays 0 and rx_enable = 1.
- busy goes high on the edge that enters START and low on the edge that returns to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP (3 bits);
  - PARITY_EVEN / PARITY_ODD constants, shared with the transmitter.
- One natural sub-module: uart_sync2, a 2-flop synchroniser with a reset value of 1. It is reusable for other asynchronous pins.

Test Plan:
(All scenarios use the defaults: OVERSAMPLE = 16, 8 data bits, even parity. One bit period = 16 clocks.)
1. Good frame: drive 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1. Expect rx_data = 0xA5, a single data_valid pulse, both error flags 0, and busy low after the stop bit.
2. Glitch: rx_in low for 4 clocks, then high. Expect busy to pulse high for about 8 clocks, then return to IDLE with no data_valid and rx_data unchanged.
3. Parity error: send 0xA5 with parity bit 1. Expect a parity_error pulse, data_valid = 0, rx_data = 0xA5.
4. Framing error: send 0x3C with correct parity (0) and stop bit 0. Expect a framing_error pulse, data_valid = 0, rx_data = 0x3C.
5. Back-to-back and enable: send frames 0x3C then 0xC3 with no idle gap. Expect two data_valid pulses, exactly 11 bit-periods apart. Repeat with rx_enable = 0: expect no busy and no pulses.
6. Reset mid-frame: assert rst_n = 0 for 1 clock during data bit 4. Expect all outputs 0 on the next edge, state IDLE, and no pulse for the truncated frame. The next good frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity constants shared by the UART receiver and transmitter
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous pin that idles high
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_s1;
    logic r_s2;
    // Two stages to settle metastability; both stages reset to the idle-high level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end
    assign o_q = r_s2;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver, mid-bit sampling, with parity and framing checks
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = uart_pkg::PARITY_EVEN
) (
    input  logic                  i_baud_rate_rx,
    input  logic                  i_rst_n,
    input  logic                  i_rx_enable,
    input  logic                  i_rx_in,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_data_valid,
    output logic                  o_parity_error,
    output logic                  o_framing_error,
    output logic                  o_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [TW-1:0]         r_tick;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_ok;
    logic                  w_rx_s;

    uart_sync2 u_sync (
        .i_clk   (i_baud_rate_rx),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx_in),
        .o_q     (w_rx_s)
    );

    // Frame sequencer: START waits half a bit so every later sample lands mid-bit,
    // and STOP resolves at mid stop bit so the rest of it is spent watching for the next start
    always_ff @(posedge i_baud_rate_rx) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_tick          <= '0;
            r_bit           <= '0;
            r_shift         <= '0;
            r_par_ok        <= 1'b0;
            o_rx_data       <= '0;
            o_data_valid    <= 1'b0;
            o_parity_error  <= 1'b0;
            o_framing_error <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            o_data_valid    <= 1'b0;
            o_parity_error  <= 1'b0;
            o_framing_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tick <= '0;
                    if (i_rx_enable && !w_rx_s) begin
                        r_state <= START;
                        o_busy  <= 1'b1;
                    end
                end
                START: begin
                    r_tick <= (r_tick == T_MID) ? '0 : r_tick + 1'b1;
                    if (r_tick == T_MID) begin
                        r_state <= w_rx_s ? IDLE : DATA;
                        o_busy  <= !w_rx_s;
                    end
                end
                DATA: begin
                    r_tick <= (r_tick == T_END) ? '0 : r_tick + 1'b1;
                    if (r_tick == T_END) begin
                        r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                        r_bit   <= (r_bit == B_LAST) ? '0 : r_bit + 1'b1;
                        if (r_bit == B_LAST)
                            r_state <= PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    r_tick <= (r_tick == T_END) ? '0 : r_tick + 1'b1;
                    if (r_tick == T_END) begin
                        r_par_ok <= ~(^r_shift ^ w_rx_s ^ PARITY_ODD);
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    r_tick <= (r_tick == T_END) ? '0 : r_tick + 1'b1;
                    if (r_tick == T_END) begin
                        o_rx_data       <= r_shift;
                        o_framing_error <= ~w_rx_s;
                        o_parity_error  <= PARITY_EN & ~r_par_ok;
                        o_data_valid    <= w_rx_s & (r_par_ok | ~PARITY_EN);
                        r_state         <= IDLE;
                        o_busy          <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames with a pulse scoreboard for uart_rx_fsm
module tb_uart_rx_fsm;
    typedef struct packed {
        logic       v;
        logic       pe;
        logic       fe;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_enable = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t exp_q[$];
    int   valid_cyc[$];

    uart_rx_fsm dut (
        .i_baud_rate_rx  (clk),
        .i_rst_n         (rst_n),
        .i_rx_enable     (rx_enable),
        .i_rx_in         (rx_in),
        .o_rx_data       (rx_data),
        .o_data_valid    (data_valid),
        .o_parity_error  (parity_error),
        .o_framing_error (framing_error),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output pulse, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (data_valid || parity_error || framing_error) begin
            if (data_valid) valid_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got v/pe/fe=%b%b%b expected none", data_valid, parity_error, framing_error);
            end else begin
                e = exp_q.pop_front();
                check("pulse_flags", {29'd0, data_valid, parity_error, framing_error}, {29'd0, e.v, e.pe, e.fe});
                check("pulse_data", {24'd0, rx_data}, {24'd0, e.d});
            end
        end
    end

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'h0);
        check("rst_valid", {31'd0, data_valid}, 32'h0);
        check("rst_perr", {31'd0, parity_error}, 32'h0);
        check("rst_ferr", {31'd0, framing_error}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst_n = 1'b1;
        idle(5);

        e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: 8'hA5};
        exp_q.push_back(e);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        idle(4);
        check("good_busy_low", {31'd0, busy}, 32'h0);
        check("good_data", {24'd0, rx_data}, 32'hA5);

        busy_cnt = 0;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("glitch_busy_cycles", busy_cnt, 32'd8);
        check("glitch_data_kept", {24'd0, rx_data}, 32'hA5);

        e = '{v: 1'b0, pe: 1'b1, fe: 1'b0, d: 8'hA5};
        exp_q.push_back(e);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(4);
        check("perr_data", {24'd0, rx_data}, 32'hA5);

        e = '{v: 1'b0, pe: 1'b0, fe: 1'b1, d: 8'h3C};
        exp_q.push_back(e);
        send_frame(8'h3C, ^8'h3C, 1'b0);
        idle(40);
        check("ferr_data", {24'd0, rx_data}, 32'h3C);
        check("ferr_busy_low", {31'd0, busy}, 32'h0);

        valid_cyc.delete();
        e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: 8'h3C};
        exp_q.push_back(e);
        e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: 8'hC3};
        exp_q.push_back(e);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        send_frame(8'hC3, ^8'hC3, 1'b1);
        idle(8);
        check("b2b_pulse_count", valid_cyc.size(), 32'd2);
        if (valid_cyc.size() >= 2) check("b2b_gap", valid_cyc[1] - valid_cyc[0], 32'd176);
        check("b2b_data", {24'd0, rx_data}, 32'hC3);

        rx_enable = 1'b0;
        busy_cnt = 0;
        send_frame(8'h11, ^8'h11, 1'b1);
        idle(8);
        check("disabled_busy", busy_cnt, 32'd0);
        check("disabled_data", {24'd0, rx_data}, 32'hC3);
        rx_enable = 1'b1;
        idle(4);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'h0);
        check("midrst_data", {24'd0, rx_data}, 32'h0);
        check("midrst_flags", {29'd0, data_valid, parity_error, framing_error}, 32'h0);
        idle(48);
        check("midrst_stays_idle", {31'd0, busy}, 32'h0);
        e = '{v: 1'b1, pe: 1'b0, fe: 1'b0, d: 8'h5A};
        exp_q.push_back(e);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        idle(8);
        check("after_rst_data", {24'd0, rx_data}, 32'h5A);

        idle(20);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
